// File: rtl/fifo_sync_ctrl.sv
// Single-clock pointer/flag controller for a dual-port FIFO memory (fifomem).
// Optional sticky overflow/underflow flags are built when FIFO_ERR_EN is defined.
module fifo_sync_ctrl #(
    parameter int ADDRSIZE   = 4,
    parameter int AFULL_LVL  = 14,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                winc,
    input  logic                rinc,
    input  logic                err_clr,
    output logic                wclken,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                wfull,
    output logic                rempty,
    output logic [ADDRSIZE:0]   count,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                ovf,
    output logic                udf
);

    localparam logic [ADDRSIZE:0] DEPTH_W  = (ADDRSIZE+1)'(1 << ADDRSIZE);
    localparam logic [ADDRSIZE:0] ONE_W    = (ADDRSIZE+1)'(1);
    localparam logic [ADDRSIZE:0] AFULL_W  = (ADDRSIZE+1)'(AFULL_LVL);
    localparam logic [ADDRSIZE:0] AEMPTY_W = (ADDRSIZE+1)'(AEMPTY_LVL);

    logic [ADDRSIZE:0] wptr;
    logic [ADDRSIZE:0] rptr;
    logic [ADDRSIZE:0] count_next;
    logic              wacc;
    logic              racc;

    // Acceptance uses the registered flags, so a full FIFO rejects a write
    // even when a read frees a slot on the same edge (and vice versa for empty).
    assign wacc   = winc & ~wfull;
    assign racc   = rinc & ~rempty;
    assign wclken = wacc & ~rst;
    assign waddr  = wptr[ADDRSIZE-1:0];
    assign raddr  = rptr[ADDRSIZE-1:0];

    always_comb begin
        count_next = count;
        case ({wacc, racc})
            2'b10:   count_next = count + ONE_W;
            2'b01:   count_next = count - ONE_W;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            wfull        <= 1'b0;
            rempty       <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wacc)
                wptr <= wptr + ONE_W;
            if (racc)
                rptr <= rptr + ONE_W;
            count        <= count_next;
            wfull        <= (count_next == DEPTH_W);
            rempty       <= (count_next == '0);
            almost_full  <= (count_next >= AFULL_W);
            almost_empty <= (count_next <= AEMPTY_W);
        end
    end

`ifdef FIFO_ERR_EN
    // Sticky error flags; a new error on the clearing edge keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= (winc & wfull)  | (ovf & ~err_clr);
            udf <= (rinc & rempty) | (udf & ~err_clr);
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign ovf            = 1'b0;
    assign udf            = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed bench for fifo_sync_ctrl with a bench-side fifomem and a small
// occupancy/pointer model; ends with a bounded random soak.
module tb_fifo_sync_ctrl;

    logic       clk;
    logic       rst;
    logic       winc;
    logic       rinc;
    logic       err_clr;
    logic       wclken;
    logic [3:0] waddr;
    logic [3:0] raddr;
    logic       wfull;
    logic       rempty;
    logic [4:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic       ovf;
    logic       udf;

    logic [7:0] mem [16];
    logic [7:0] wdata;
    logic [7:0] rdata;

    int checks   = 0;
    int failures = 0;

    int         mcount;
    int         mwp;
    int         mrp;
    int         movf;
    int         mudf;
    logic [7:0] wval;
    logic [7:0] q [$];

`ifdef FIFO_ERR_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    fifo_sync_ctrl #(.ADDRSIZE(4), .AFULL_LVL(14), .AEMPTY_LVL(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .winc         (winc),
        .rinc         (rinc),
        .err_clr      (err_clr),
        .wclken       (wclken),
        .waddr        (waddr),
        .raddr        (raddr),
        .wfull        (wfull),
        .rempty       (rempty),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf          (ovf),
        .udf          (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (wclken)
            mem[waddr] <= wdata;

    assign rdata = mem[raddr];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mcount = 0;
        mwp    = 0;
        mrp    = 0;
        movf   = 0;
        mudf   = 0;
        q.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"},  int'(count),        mcount);
        chk({tag, ".wfull"},  int'(wfull),        int'(mcount == 16));
        chk({tag, ".rempty"}, int'(rempty),       int'(mcount == 0));
        chk({tag, ".afull"},  int'(almost_full),  int'(mcount >= 14));
        chk({tag, ".aempty"}, int'(almost_empty), int'(mcount <= 2));
        chk({tag, ".waddr"},  int'(waddr),        mwp % 16);
        chk({tag, ".raddr"},  int'(raddr),        mrp % 16);
        chk({tag, ".ovf"},    int'(ovf),          movf & ERR_EN);
        chk({tag, ".udf"},    int'(udf),          mudf & ERR_EN);
    endtask

    // One clock with the given requests; entered and left at posedge+1.
    task automatic cyc(input string tag, input logic w, input logic r, input logic clr);
        int wa;
        int ra;
        winc    = w;
        rinc    = r;
        err_clr = clr;
        wdata   = wval;
        wa = int'(w) & int'(mcount != 16);
        ra = int'(r) & int'(mcount != 0);
        #1;
        chk({tag, ".wclken"}, int'(wclken), wa);
        if (ra != 0)
            chk({tag, ".rdata"}, int'(rdata), int'(q[0]));
        @(posedge clk);
        #1;
        movf = (int'(w) & int'(mcount == 16)) | (movf & int'(!clr));
        mudf = (int'(r) & int'(mcount == 0))  | (mudf & int'(!clr));
        if (wa != 0) begin
            q.push_back(wval);
            wval = wval + 8'd1;
            mwp  = (mwp + 1) % 32;
        end
        if (ra != 0) begin
            void'(q.pop_front());
            mrp = (mrp + 1) % 32;
        end
        mcount = mcount + wa - ra;
        winc    = 1'b0;
        rinc    = 1'b0;
        err_clr = 1'b0;
        check_state(tag);
        if (wfull && rempty)
            chk("both_flags", 1, 0);
    endtask

    initial begin
        int w0;
        int r0;
        rst     = 1'b1;
        winc    = 1'b1;
        rinc    = 1'b0;
        err_clr = 1'b0;
        wdata   = 8'd0;
        wval    = 8'd0;
        model_reset();

        // 1. reset, including an async pulse in the middle of traffic
        repeat (2) @(posedge clk);
        #1;
        chk("rst.wclken", int'(wclken), 0);
        check_state("rst");
        rst  = 1'b0;
        winc = 1'b0;
        cyc("pre", 1'b1, 1'b0, 1'b0);
        cyc("pre", 1'b1, 1'b0, 1'b0);
        cyc("pre", 1'b1, 1'b1, 1'b0);
        winc = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst.wclken", int'(wclken), 0);
        check_state("midrst");
        @(posedge clk);
        #1;
        rst  = 1'b0;
        winc = 1'b0;

        // 2. fill to full, then one overflow attempt
        wval = 8'd0;
        for (int i = 0; i < 16; i++)
            cyc("fill", 1'b1, 1'b0, 1'b0);
        chk("fill.wfull", int'(wfull), 1);
        chk("fill.afull", int'(almost_full), 1);
        cyc("ovf", 1'b1, 1'b0, 1'b0);
        chk("ovf.count", int'(count), 16);

        // 3. drain in write order, one underflow attempt, then clear errors
        for (int i = 0; i < 16; i++) begin
            chk("drain.data", int'(rdata), i);
            cyc("drain", 1'b0, 1'b1, 1'b0);
        end
        chk("drain.rempty", int'(rempty), 1);
        r0 = int'(raddr);
        cyc("udf", 1'b0, 1'b1, 1'b0);
        chk("udf.raddr", int'(raddr), r0);
        cyc("clr", 1'b0, 1'b0, 1'b1);
        chk("clr.ovf", int'(ovf), 0);
        chk("clr.udf", int'(udf), 0);

        // 4. simultaneous requests at full, empty and mid-level
        for (int i = 0; i < 16; i++)
            cyc("fill2", 1'b1, 1'b0, 1'b0);
        w0 = int'(waddr);
        r0 = int'(raddr);
        cyc("simfull", 1'b1, 1'b1, 1'b0);
        chk("simfull.count", int'(count), 15);
        chk("simfull.waddr", int'(waddr), w0);
        chk("simfull.raddr", int'(raddr), (r0 + 1) % 16);
        for (int i = 0; i < 15; i++)
            cyc("drain2", 1'b0, 1'b1, 1'b0);
        w0 = int'(waddr);
        r0 = int'(raddr);
        cyc("simempty", 1'b1, 1'b1, 1'b0);
        chk("simempty.count", int'(count), 1);
        chk("simempty.waddr", int'(waddr), (w0 + 1) % 16);
        chk("simempty.raddr", int'(raddr), r0);
        for (int i = 0; i < 7; i++)
            cyc("to8", 1'b1, 1'b0, 1'b0);
        w0 = int'(waddr);
        r0 = int'(raddr);
        cyc("sim8", 1'b1, 1'b1, 1'b0);
        chk("sim8.count", int'(count), 8);
        chk("sim8.waddr", int'(waddr), (w0 + 1) % 16);
        chk("sim8.raddr", int'(raddr), (r0 + 1) % 16);
        for (int i = 0; i < 8; i++)
            cyc("drain3", 1'b0, 1'b1, 1'b0);
        cyc("clr2", 1'b0, 1'b0, 1'b1);

        // 5. wrap: 40 writes with reads once occupancy reaches 3
        for (int i = 0; i < 40; i++)
            cyc("wrap", 1'b1, logic'(mcount >= 3), 1'b0);
        while (mcount > 0)
            cyc("wrapdrain", 1'b0, 1'b1, 1'b0);

        // 6. random soak: write-biased then read-biased phases
        for (int i = 0; i < 3000; i++) begin
            logic w;
            logic r;
            if (i < 1500) begin
                w = logic'($urandom_range(0, 3) != 0);
                r = logic'($urandom_range(0, 3) == 0);
            end else begin
                w = logic'($urandom_range(0, 3) == 0);
                r = logic'($urandom_range(0, 3) != 0);
            end
            cyc("rand", w, r, logic'($urandom_range(0, 31) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
